// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the fault-tolerance error-reporting path.
package cv32e40p_ft_pkg;

    localparam int unsigned FT_NSRC  = 8;
    localparam int unsigned FT_SRC_W = $clog2(FT_NSRC);

    localparam logic FT_EVT_DET = 1'b1;
    localparam logic FT_EVT_COR = 1'b0;

    typedef struct packed {
        logic                detected;
        logic [FT_SRC_W-1:0] src;
    } ft_evt_t;

endpackage

// File: rtl/cv32e40p_ft_err_collector_if.sv
// Event stream from the error collector to its consumer (debug/CSR logic).
interface cv32e40p_ft_err_collector_if;
    import cv32e40p_ft_pkg::*;

    logic                evt_valid_o;
    logic                evt_ready_i;
    logic                evt_detected_o;
    logic [FT_SRC_W-1:0] evt_src_o;

    modport master (output evt_valid_o, output evt_detected_o, output evt_src_o, input evt_ready_i);
    modport slave  (input evt_valid_o, input evt_detected_o, input evt_src_o, output evt_ready_i);
endinterface

// File: rtl/cv32e40p_ff_one.sv
// Find-first-one: index of the lowest set bit and an all-zero flag.
module cv32e40p_ff_one #(
    parameter int unsigned LEN = 8
) (
    input  logic [LEN-1:0]         in_i,
    output logic [$clog2(LEN)-1:0] first_one_o,
    output logic                   no_ones_o
);
    localparam int unsigned IDX_W = $clog2(LEN);

    always_comb begin
        first_one_o = '0;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (in_i[i]) first_one_o = IDX_W'(i);
        end
    end

    assign no_ones_o = ~|in_i;
endmodule

// File: rtl/cv32e40p_ft_evt_fifo.sv
// Event FIFO with wrap-bit pointers; head is read straight out of storage flops.
module cv32e40p_ft_evt_fifo
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clear_i,
    input  logic    push_i,
    input  ft_evt_t data_i,
    input  logic    pop_i,
    output ft_evt_t data_o,
    output logic    full_o,
    output logic    empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    ft_evt_t     mem_q [DEPTH];
    ft_evt_t     mem_d [DEPTH];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wptr_q[AW-1:0]] = data_i;
                wptr_d = wptr_q + (AW+1)'(1);
            end
            if (pop_i) rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign full_o  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    assign empty_o = (wptr_q == rptr_q);
endmodule

// File: rtl/cv32e40p_ft_err_collector.sv
// Collects TMR voter error pulses as sticky pending bits and serializes them into an event FIFO.
// Event counters are built only when CV32E40P_FT_ERR_CNT_EN is defined; otherwise they read 0.
module cv32e40p_ft_err_collector
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned NSRC  = FT_NSRC,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NSRC-1:0]               error_correct_i,
    input  logic [NSRC-1:0]               error_detected_i,
    input  logic                          clear_i,
    cv32e40p_ft_err_collector_if.master   evt_if,
    output logic [CNT_W-1:0]              cnt_correct_o,
    output logic [CNT_W-1:0]              cnt_detected_o,
    output logic                          lost_o,
    output logic                          irq_o
);
    localparam int unsigned SRC_W = $clog2(NSRC);

    logic [NSRC-1:0]  pend_cor_q, pend_cor_d, pend_det_q, pend_det_d;
    logic [NSRC-1:0]  mask_cor, mask_det;
    logic             lost_q, lost_d;
    logic [SRC_W-1:0] det_idx, cor_idx;
    logic             det_none, cor_none;
    logic             fifo_full, fifo_empty;
    logic             pop, push, push_det, push_cor;
    ft_evt_t          push_evt, head_evt;

    cv32e40p_ff_one #(.LEN(NSRC)) u_ff_det (.in_i(pend_det_q), .first_one_o(det_idx), .no_ones_o(det_none));
    cv32e40p_ff_one #(.LEN(NSRC)) u_ff_cor (.in_i(pend_cor_q), .first_one_o(cor_idx), .no_ones_o(cor_none));

    // Detected events win; a full FIFO accepts a push only alongside a pop.
    always_comb begin
        pop      = !fifo_empty && evt_if.evt_ready_i && !clear_i;
        push     = !(det_none && cor_none) && (!fifo_full || pop) && !clear_i;
        push_det = push && !det_none;
        push_cor = push && det_none;
        push_evt.detected = det_none ? FT_EVT_COR : FT_EVT_DET;
        push_evt.src      = det_none ? cor_idx : det_idx;
        mask_det = push_det ? (NSRC'(1) << det_idx) : '0;
        mask_cor = push_cor ? (NSRC'(1) << cor_idx) : '0;
    end

    // A pulse on a still-pending, not-being-pushed bit is coalesced and flagged lost.
    always_comb begin
        pend_cor_d = (pend_cor_q & ~mask_cor) | error_correct_i;
        pend_det_d = (pend_det_q & ~mask_det) | error_detected_i;
        lost_d     = lost_q
                   | (|(error_correct_i  & pend_cor_q & ~mask_cor))
                   | (|(error_detected_i & pend_det_q & ~mask_det));
        if (clear_i) begin
            pend_cor_d = error_correct_i;
            pend_det_d = error_detected_i;
            lost_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cor_q <= '0;
            pend_det_q <= '0;
            lost_q     <= 1'b0;
        end else begin
            pend_cor_q <= pend_cor_d;
            pend_det_q <= pend_det_d;
            lost_q     <= lost_d;
        end
    end

    cv32e40p_ft_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear_i),
        .push_i  (push),
        .data_i  (push_evt),
        .pop_i   (pop),
        .data_o  (head_evt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef CV32E40P_FT_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_cor_q, cnt_cor_d, cnt_det_q, cnt_det_d;

    // Saturating counters, one per event type.
    always_comb begin
        cnt_cor_d = cnt_cor_q;
        cnt_det_d = cnt_det_q;
        if (clear_i) begin
            cnt_cor_d = '0;
            cnt_det_d = '0;
        end else begin
            if (push_cor && !(&cnt_cor_q)) cnt_cor_d = cnt_cor_q + CNT_W'(1);
            if (push_det && !(&cnt_det_q)) cnt_det_d = cnt_det_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_cor_q <= '0;
            cnt_det_q <= '0;
        end else begin
            cnt_cor_q <= cnt_cor_d;
            cnt_det_q <= cnt_det_d;
        end
    end

    assign cnt_correct_o  = cnt_cor_q;
    assign cnt_detected_o = cnt_det_q;
`else
    assign cnt_correct_o  = '0;
    assign cnt_detected_o = '0;
`endif

    assign evt_if.evt_valid_o    = !fifo_empty;
    assign evt_if.evt_detected_o = head_evt.detected;
    assign evt_if.evt_src_o      = head_evt.src;
    assign lost_o                = lost_q;
    assign irq_o                 = !fifo_empty || (|pend_det_q);
endmodule

// File: tb/tb_cv32e40p_ft_err_collector.sv
// Directed + random bench for the error collector against a queue-based reference model.
module tb_cv32e40p_ft_err_collector;
    localparam int NSRC  = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef CV32E40P_FT_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct { bit det; int src; } evt_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NSRC-1:0]  cor_i = '0, det_i = '0;
    logic             clr_i = 1'b0;
    logic [CNT_W-1:0] cnt_c, cnt_d;
    logic             lost, irq;

    cv32e40p_ft_err_collector_if evt_if ();

    cv32e40p_ft_err_collector #(.NSRC(NSRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .error_correct_i  (cor_i),
        .error_detected_i (det_i),
        .clear_i          (clr_i),
        .evt_if           (evt_if),
        .cnt_correct_o    (cnt_c),
        .cnt_detected_o   (cnt_d),
        .lost_o           (lost),
        .irq_o            (irq)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    bit   m_pc [NSRC];
    bit   m_pd [NSRC];
    evt_t m_q [$];
    int   m_ncor, m_ndet;
    bit   m_lost;
    int   popped [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n);
        return CNT_EN ? ((n > CMAX) ? CMAX : n) : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) begin m_pc[i] = 0; m_pd[i] = 0; end
        m_q.delete();
        m_ncor = 0; m_ndet = 0; m_lost = 0;
    endtask

    // One clock of the event-collection rules, applied to the pre-edge model state.
    task automatic model_edge(input logic [NSRC-1:0] c, input logic [NSRC-1:0] d, input bit rdy, input bit clr);
        int sel = -1;
        bit sel_det = 0;
        bit pop, push;
        for (int i = 0; i < NSRC; i++) if (sel < 0 && m_pd[i]) begin sel = i; sel_det = 1; end
        for (int i = 0; i < NSRC; i++) if (sel < 0 && m_pc[i]) sel = i;
        pop  = (m_q.size() > 0) && rdy && !clr;
        push = (sel >= 0) && (m_q.size() < DEPTH || pop) && !clr;
        if (clr) begin
            m_q.delete();
            m_ncor = 0; m_ndet = 0; m_lost = 0;
            for (int i = 0; i < NSRC; i++) begin m_pc[i] = c[i]; m_pd[i] = d[i]; end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (c[i] && m_pc[i] && !(push && !sel_det && sel == i)) m_lost = 1;
                if (d[i] && m_pd[i] && !(push && sel_det && sel == i)) m_lost = 1;
            end
            if (push) begin
                if (sel_det) begin m_pd[sel] = 0; m_ndet++; end
                else         begin m_pc[sel] = 0; m_ncor++; end
            end
            if (pop) m_q.pop_front();
            if (push) m_q.push_back('{det: sel_det, src: sel});
            for (int i = 0; i < NSRC; i++) begin
                m_pc[i] = m_pc[i] | c[i];
                m_pd[i] = m_pd[i] | d[i];
            end
        end
    endtask

    task automatic compare_all(input string tag);
        bit anyd = 0;
        for (int i = 0; i < NSRC; i++) anyd |= m_pd[i];
        chk({tag, ".valid"}, 32'(evt_if.evt_valid_o), 32'(m_q.size() > 0));
        chk({tag, ".irq"},   32'(irq),   32'((m_q.size() > 0) || anyd));
        chk({tag, ".lost"},  32'(lost),  32'(m_lost));
        chk({tag, ".cnt_c"}, 32'(cnt_c), 32'(sat(m_ncor)));
        chk({tag, ".cnt_d"}, 32'(cnt_d), 32'(sat(m_ndet)));
        if (m_q.size() > 0) begin
            chk({tag, ".det"}, 32'(evt_if.evt_detected_o), 32'(m_q[0].det));
            chk({tag, ".src"}, 32'(evt_if.evt_src_o),      32'(m_q[0].src));
        end
    endtask

    task automatic step(input string tag, input logic [NSRC-1:0] c, input logic [NSRC-1:0] d,
                        input bit rdy, input bit clr);
        @(negedge clk);
        cor_i = c; det_i = d; evt_if.evt_ready_i = rdy; clr_i = clr;
        if (evt_if.evt_valid_o && rdy && !clr) popped.push_back(int'(evt_if.evt_src_o));
        model_edge(c, d, rdy, clr);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        evt_if.evt_ready_i = 1'b0;
        model_reset();
        #12;
        chk("reset.valid", 32'(evt_if.evt_valid_o), 32'd0);
        chk("reset.det",   32'(evt_if.evt_detected_o), 32'd0);
        chk("reset.src",   32'(evt_if.evt_src_o), 32'd0);
        chk("reset.irq",   32'(irq), 32'd0);
        chk("reset.lost",  32'(lost), 32'd0);
        chk("reset.cnt_c", 32'(cnt_c), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single corrected event on source 2
        step("single0", 8'h04, 8'h00, 1, 0);
        chk("single.pend_only", 32'(evt_if.evt_valid_o), 32'd0);
        step("single1", 8'h00, 8'h00, 1, 0);
        chk("single.valid", 32'(evt_if.evt_valid_o), 32'd1);
        chk("single.src",   32'(evt_if.evt_src_o), 32'd2);
        chk("single.det",   32'(evt_if.evt_detected_o), 32'd0);
        chk("single.cnt",   32'(cnt_c), CNT_EN ? 32'd1 : 32'd0);
        step("single2", 8'h00, 8'h00, 1, 0);
        chk("single.one_cycle", 32'(evt_if.evt_valid_o), 32'd0);

        // Detected beats corrected
        step("prio0", 8'h01, 8'h80, 1, 0);
        step("prio1", 8'h00, 8'h00, 1, 0);
        chk("prio.first_det", 32'(evt_if.evt_detected_o), 32'd1);
        chk("prio.first_src", 32'(evt_if.evt_src_o), 32'd7);
        step("prio2", 8'h00, 8'h00, 1, 0);
        chk("prio.second_det", 32'(evt_if.evt_detected_o), 32'd0);
        chk("prio.second_src", 32'(evt_if.evt_src_o), 32'd0);
        repeat (2) step("prio_idle", 8'h00, 8'h00, 1, 0);

        // Backpressure: 6 events into a 4-deep FIFO
        step("full0", 8'h3F, 8'h00, 0, 0);
        repeat (6) step("full_hold", 8'h00, 8'h00, 0, 0);
        chk("full.no_loss", 32'(lost), 32'd0);
        step("full_repulse", 8'h20, 8'h00, 0, 0);
        chk("full.lost", 32'(lost), 32'd1);
        popped.delete();
        repeat (9) step("full_drain", 8'h00, 8'h00, 1, 0);
        chk("full.count", 32'(popped.size()), 32'd6);
        for (int i = 0; i < popped.size(); i++) chk("full.order", 32'(popped[i]), 32'(i));

        // Saturation of the corrected counter
        for (int r = 0; r < 3; r++) begin
            step("sat_burst", (r == 2) ? 8'h0F : 8'hFF, 8'h00, 1, 0);
            repeat (10) step("sat_drain", 8'h00, 8'h00, 1, 0);
        end
        chk("sat.cnt_c", 32'(cnt_c), CNT_EN ? 32'(CMAX) : 32'd0);
        step("clear", 8'h00, 8'h02, 1, 1);
        chk("clear.valid", 32'(evt_if.evt_valid_o), 32'd0);
        chk("clear.cnt_c", 32'(cnt_c), 32'd0);
        chk("clear.lost",  32'(lost), 32'd0);
        step("clear_evt", 8'h00, 8'h00, 0, 0);
        chk("clear_evt.det", 32'(evt_if.evt_detected_o), 32'd1);
        chk("clear_evt.src", 32'(evt_if.evt_src_o), 32'd1);
        step("clear_pop", 8'h00, 8'h00, 1, 0);

        // Asynchronous reset with entries queued and lost set
        step("mid0", 8'h07, 8'h00, 0, 0);
        step("mid1", 8'h04, 8'h00, 0, 0);
        repeat (3) step("mid_hold", 8'h00, 8'h00, 0, 0);
        chk("mid.lost_set", 32'(lost), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async.valid", 32'(evt_if.evt_valid_o), 32'd0);
        chk("async.lost",  32'(lost), 32'd0);
        chk("async.cnt_c", 32'(cnt_c), 32'd0);
        chk("async.irq",   32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [NSRC-1:0] c, d;
            c = NSRC'($urandom & $urandom & $urandom);
            d = NSRC'($urandom & $urandom & $urandom & $urandom);
            step("rand", c, d, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
